mux_lut_gate_pipe: RTL and testbench

//  Parametrised, pipelined successor to the single-bit mux-built inverter.

---
 rtl/mux_lut_gate_pipe_pkg.sv | 14 +
 rtl/mux_lut_gate_pipe_lut2_mux.sv | 21 ++
 rtl/mux_lut_gate_pipe.sv | 85 ++++++++
 tb/tb_mux_lut_gate_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_lut_gate_pipe_pkg.sv
// Shared types and truth-table constants for the LUT-gate pipeline.
// Truth-table bit index is {a,b}.
package mux_lut_pkg;

   typedef logic [3:0] tt_t;

   localparam tt_t TT_NOT_A = 4'b0011;
   localparam tt_t TT_AND   = 4'b1000;
   localparam tt_t TT_OR    = 4'b1110;
   localparam tt_t TT_XOR   = 4'b0110;
   localparam tt_t TT_NAND  = 4'b0111;
   localparam tt_t TT_RESET = TT_NOT_A;

endpackage

// File: rtl/mux_lut_gate_pipe_lut2_mux.sv
// One lane of the LUT gate: a 4:1 mux selecting a truth-table bit by {a,b}.
module lut2_mux
   import mux_lut_pkg::*;
(
   input  tt_t  i_tt,
   input  logic i_a,
   input  logic i_b,
   output logic o_o
);

   always_comb begin
      o_o = i_tt[0];
      case ({i_a, i_b})
         2'b00: o_o = i_tt[0];
         2'b01: o_o = i_tt[1];
         2'b10: o_o = i_tt[2];
         2'b11: o_o = i_tt[3];
      endcase
   end

endmodule

// File: rtl/mux_lut_gate_pipe.sv
// W-lane runtime-programmable 2-input gate with a STAGES-deep valid/ready pipeline.
// The truth table is bound to each beat at acceptance; later writes never reach beats in flight.
module mux_lut_gate_pipe
   import mux_lut_pkg::*;
#(
   parameter int unsigned W      = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_we,
   input  logic [3:0]   cfg_tt,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] o,
   output logic [3:0]   tt_cur
);

   tt_t          r_tt;
   logic [W-1:0] w_f;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tt <= TT_RESET;
      end else if (cfg_we) begin
         r_tt <= cfg_tt;
      end
   end

   assign tt_cur = r_tt;

   for (genvar i = 0; i < W; i++) begin : g_lane
      lut2_mux u_lut (
         .i_tt (r_tt),
         .i_a  (a[i]),
         .i_b  (b[i]),
         .o_o  (w_f[i])
      );
   end

   // Per-stage signals live inside each generate block so the ready chain
   // is a series of distinct nets rather than one self-referencing vector.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic         r_valid;
      logic [W-1:0] r_data;
      logic         w_ready;
      logic         w_up_valid;
      logic [W-1:0] w_up_data;

      if (k == 0) begin : g_head
         assign w_up_valid = in_valid;
         assign w_up_data  = w_f;
      end else begin : g_body
         assign w_up_valid = g_stage[k-1].r_valid;
         assign w_up_data  = g_stage[k-1].r_data;
      end

      if (k == STAGES - 1) begin : g_tail
         assign w_ready = ~r_valid | out_ready;
      end else begin : g_mid
         assign w_ready = ~r_valid | g_stage[k+1].w_ready;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
         end else if (w_ready) begin
            r_valid <= w_up_valid;
            if (w_up_valid) begin
               r_data <= w_up_data;
            end
         end
      end
   end

   assign in_ready  = g_stage[0].w_ready;
   assign out_valid = g_stage[STAGES-1].r_valid;
   assign o         = g_stage[STAGES-1].r_data;

endmodule

// File: tb/tb_mux_lut_gate_pipe.sv
// Bench for mux_lut_gate_pipe: three configurations share stimulus, each tracked by a beat queue.
module tb_mux_lut_gate_pipe;
   import mux_lut_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_we;
   logic [3:0]  cfg_tt;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] a_bus;
   logic [31:0] b_bus;

   logic        ir0, ov0, ir1, ov1, ir2, ov2;
   logic [7:0]  o0;
   logic [0:0]  o1;
   logic [31:0] o2;
   logic [3:0]  tt0, tt1, tt2;

   always #5 clk = ~clk;

   mux_lut_gate_pipe #(.W(8), .STAGES(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_tt(cfg_tt),
      .in_valid(in_valid), .in_ready(ir0), .a(a_bus[7:0]), .b(b_bus[7:0]),
      .out_valid(ov0), .out_ready(out_ready), .o(o0), .tt_cur(tt0));

   mux_lut_gate_pipe #(.W(1), .STAGES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_tt(cfg_tt),
      .in_valid(in_valid), .in_ready(ir1), .a(a_bus[0:0]), .b(b_bus[0:0]),
      .out_valid(ov1), .out_ready(out_ready), .o(o1), .tt_cur(tt1));

   mux_lut_gate_pipe #(.W(32), .STAGES(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_tt(cfg_tt),
      .in_valid(in_valid), .in_ready(ir2), .a(a_bus), .b(b_bus),
      .out_valid(ov2), .out_ready(out_ready), .o(o2), .tt_cur(tt2));

   int          WD [3] = '{8, 1, 32};
   int          SD [3] = '{2, 1, 4};
   logic [31:0] q [3][$];
   logic [31:0] pop_log [$];
   logic [3:0]  tt_m;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          acc0;

   logic        obs_ir [3];
   logic        obs_ov [3];
   logic [31:0] obs_o  [3];
   logic [3:0]  obs_tt [3];
   logic        prev_stall [3];
   logic [31:0] prev_o [3];

   // Reference: output lane i is the truth-table entry addressed by 2*a[i]+b[i].
   function automatic logic [31:0] lut_ref(input logic [3:0] tt, input logic [31:0] x,
                                           input logic [31:0] y, input int w);
      logic [31:0] r;
      int          idx;
      r = '0;
      for (int i = 0; i < w; i++) begin
         idx  = 2 * int'(x[i]) + int'(y[i]);
         r[i] = tt[idx];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      obs_ir[0] = ir0; obs_ov[0] = ov0; obs_o[0] = {24'b0, o0}; obs_tt[0] = tt0;
      obs_ir[1] = ir1; obs_ov[1] = ov1; obs_o[1] = {31'b0, o1}; obs_tt[1] = tt1;
      obs_ir[2] = ir2; obs_ov[2] = ov2; obs_o[2] = o2;          obs_tt[2] = tt2;
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      logic [31:0] exp;
      #1;
      sample();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("in_ready[%0d]", d), {31'b0, obs_ir[d]},
             {31'b0, (out_ready || q[d].size() < SD[d])});
         chk($sformatf("tt_cur[%0d]", d), {28'b0, obs_tt[d]}, {28'b0, tt_m});
         if (prev_stall[d]) begin
            chk($sformatf("stall_valid[%0d]", d), {31'b0, obs_ov[d]}, 32'd1);
            chk($sformatf("stall_data[%0d]", d), obs_o[d], prev_o[d]);
         end
         if (obs_ov[d]) begin
            chk($sformatf("spurious[%0d]", d), {31'b0, q[d].size() != 0}, 32'd1);
            if (out_ready && q[d].size() != 0) begin
               exp = q[d].pop_front();
               chk($sformatf("data[%0d]", d), obs_o[d], exp);
               if (d == 0) pop_log.push_back(obs_o[0]);
            end
         end
         prev_stall[d] = obs_ov[d] && !out_ready;
         prev_o[d]     = obs_o[d];
         if (in_valid && obs_ir[d]) begin
            q[d].push_back(lut_ref(tt_m, a_bus, b_bus, WD[d]));
            if (d == 0) acc0++;
         end
      end
      if (cfg_we) tt_m = cfg_tt;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      sample();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_valid[%0d]", d), {31'b0, obs_ov[d]}, 32'd0);
         chk($sformatf("rst_o[%0d]", d), obs_o[d], 32'd0);
         chk($sformatf("rst_tt[%0d]", d), {28'b0, obs_tt[d]}, {28'b0, TT_RESET});
         q[d].delete();
         prev_stall[d] = 1'b0;
      end
      tt_m = TT_RESET;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int i;
      in_valid  = 1'b0;
      cfg_we    = 1'b0;
      out_ready = 1'b1;
      i = 0;
      while (i < 20 && (q[0].size() + q[1].size() + q[2].size()) != 0) begin
         step();
         i++;
      end
      for (int d = 0; d < 3; d++)
         chk($sformatf("drain[%0d]", d), q[d].size(), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_tt = '0; in_valid = 1'b0; out_ready = 1'b0;
      a_bus = '0; b_bus = '0; tt_m = TT_RESET; acc0 = 0;
      for (int d = 0; d < 3; d++) begin prev_stall[d] = 1'b0; prev_o[d] = '0; end
      @(negedge clk);
      do_reset();
      step();
      chk("ready_after_release", {31'b0, ir0}, 32'd1);

      // Legacy NOT behaviour and two-cycle latency.
      out_ready = 1'b1;
      a_bus = 32'hA5A5A5A5; b_bus = 32'h0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lat_not_yet", {31'b0, ov0}, 32'd0);
      step();
      chk("lat_valid", {31'b0, ov0}, 32'd1);
      chk("lat_data", {24'b0, o0}, 32'h5A);
      drain();

      // XOR then AND on the same operands.
      pop_log.delete();
      cfg_we = 1'b1; cfg_tt = TT_XOR; step(); cfg_we = 1'b0;
      a_bus = 32'hF0F0F0F0; b_bus = 32'hCCCCCCCC; in_valid = 1'b1; step();
      drain();
      chk("xor_result", pop_log[pop_log.size()-1], 32'h3C);
      cfg_we = 1'b1; cfg_tt = TT_AND; step(); cfg_we = 1'b0;
      in_valid = 1'b1; step();
      drain();
      chk("and_result", pop_log[pop_log.size()-1], 32'hC0);

      // Config write coincident with acceptance keeps the old table for that beat.
      pop_log.delete();
      a_bus = 32'h0F0F0F0F; b_bus = 32'hF0F0F0F0;
      cfg_we = 1'b1; cfg_tt = TT_OR; in_valid = 1'b1; step();
      cfg_we = 1'b0; step();
      drain();
      chk("bind_count", pop_log.size(), 32'd2);
      chk("bind_old", pop_log[0], 32'h00);
      chk("bind_new", pop_log[1], 32'hFF);

      // Back-pressure with four beats.
      pop_log.delete();
      acc0 = 0; out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_bus = $urandom; b_bus = $urandom; step();
      end
      chk("full_ready", {31'b0, ir0}, 32'd0);
      chk("full_accepts", acc0, 32'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 10 && acc0 < 4; i++) begin
         a_bus = $urandom; b_bus = $urandom; step();
      end
      chk("bp_accepts", acc0, 32'd4);
      drain();
      chk("bp_delivered", pop_log.size(), 32'd4);

      // Reset with beats in flight and a non-default table.
      out_ready = 1'b0; in_valid = 1'b1;
      cfg_we = 1'b1; cfg_tt = TT_NAND;
      a_bus = $urandom; b_bus = $urandom; step();
      cfg_we = 1'b0;
      a_bus = $urandom; b_bus = $urandom; step();
      in_valid = 1'b0;
      chk("inflight_valid", {31'b0, ov0}, 32'd1);
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk("no_stale", {31'b0, ov0}, 32'd0);

      // Randomised traffic with occasional reconfiguration.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cfg_we    = ($urandom_range(0, 15) == 0);
         cfg_tt    = 4'($urandom);
         a_bus     = $urandom;
         b_bus     = $urandom;
         step();
      end
      drain();

      // Every table against every {a,b} combination.
      out_ready = 1'b1;
      for (int t = 0; t < 16; t++) begin
         logic [1:0] kk;
         cfg_we = 1'b1; cfg_tt = 4'(t); in_valid = 1'b0; step();
         cfg_we = 1'b0;
         for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            a_bus = kk[1] ? '1 : '0;
            b_bus = kk[0] ? '1 : '0;
            in_valid = 1'b1; step();
         end
         a_bus = 32'hCCCCCCCC; b_bus = 32'hAAAAAAAA; step();
         in_valid = 1'b0;
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
